// File: rtl/starfield_fade_stage.sv
// starfield_fade_stage: frame-paced dithered fade-in/out between starfield generator and VGA pins
module starfield_fade_stage #(
  parameter int FRAMES_PER_STEP  = 2,
  parameter bit SYNC_ACTIVE_HIGH = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       display_on,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic [2:0] rgb_in,
  input  logic       fade_in_req,
  input  logic       fade_out_req,
  output logic       hsync,
  output logic       vsync,
  output logic [2:0] rgb,
  output logic [4:0] level,
  output logic       busy
);
  typedef enum logic [1:0] {DARK, FADE_IN, LIT, FADE_OUT} state_t;
  localparam logic [7:0]  LAST   = 8'(FRAMES_PER_STEP - 1);
  localparam logic        INACT  = ~SYNC_ACTIVE_HIGH;
  // 4x4 Bayer thresholds, nibble index = {vpos[1:0], hpos[1:0]}
  localparam logic [63:0] DITH   = 64'h5D7F_91B3_6E4C_A280;
  state_t     r_state, w_state_nxt;
  logic [4:0] r_level, w_level_nxt, w_up, w_dn, w_b;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic [2:0] r_rgb;
  logic       r_in_pend, r_out_pend, r_vsync_prev, r_hsync, r_vsync, r_busy;
  logic       w_tick, w_in, w_out, w_step, w_dith_on, w_unused;
  assign w_unused  = ^{hpos[9:2], vpos[9:2]};
  assign w_tick    = (vsync_in == SYNC_ACTIVE_HIGH) && (r_vsync_prev == INACT);
  // Requests pending together cancel each other
  assign w_in      = (r_in_pend | fade_in_req) & ~(r_out_pend | fade_out_req);
  assign w_out     = (r_out_pend | fade_out_req) & ~(r_in_pend | fade_in_req);
  assign w_step    = r_cnt == LAST;
  assign w_up      = (r_level == 5'd16) ? 5'd16 : r_level + 5'd1;
  assign w_dn      = (r_level == 5'd0) ? 5'd0 : r_level - 5'd1;
  assign w_b       = {1'b0, DITH[{vpos[1:0], hpos[1:0], 2'b00} +: 4]};
  assign w_dith_on = w_b < r_level;
  assign hsync     = r_hsync;
  assign vsync     = r_vsync;
  assign rgb       = r_rgb;
  assign level     = r_level;
  assign busy      = r_busy;
  // Next fade state, level and frame counter; only a frame tick advances anything
  always_comb begin
    w_state_nxt = r_state;
    w_level_nxt = r_level;
    w_cnt_nxt   = r_cnt;
    if (w_tick)
      case (r_state)
        DARK: if (w_in) begin
          w_state_nxt = FADE_IN;
          w_cnt_nxt   = '0;
        end
        LIT: if (w_out) begin
          w_state_nxt = FADE_OUT;
          w_cnt_nxt   = '0;
        end
        FADE_IN: if (w_out) begin
          w_state_nxt = FADE_OUT;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = w_step ? '0 : r_cnt + 8'd1;
          w_level_nxt = w_step ? w_up : r_level;
          w_state_nxt = (w_step && w_up == 5'd16) ? LIT : FADE_IN;
        end
        default: if (w_in) begin
          w_state_nxt = FADE_IN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = w_step ? '0 : r_cnt + 8'd1;
          w_level_nxt = w_step ? w_dn : r_level;
          w_state_nxt = (w_step && w_dn == 5'd0) ? DARK : FADE_OUT;
        end
      endcase
  end
  // Fade state registers and request latches; a tick consumes all pending requests
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= DARK;
      r_level    <= '0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_in_pend  <= 1'b0;
      r_out_pend <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_level    <= w_level_nxt;
      r_cnt      <= w_cnt_nxt;
      r_busy     <= (w_state_nxt == FADE_IN) || (w_state_nxt == FADE_OUT);
      r_in_pend  <= w_tick ? 1'b0 : r_in_pend | fade_in_req;
      r_out_pend <= w_tick ? 1'b0 : r_out_pend | fade_out_req;
    end
  end
  // Pixel and sync pipeline: one register stage keeps rgb aligned with the syncs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rgb        <= '0;
      r_hsync      <= INACT;
      r_vsync      <= INACT;
      r_vsync_prev <= INACT;
    end else begin
      r_rgb        <= (display_on && w_dith_on) ? rgb_in : 3'd0;
      r_hsync      <= hsync_in;
      r_vsync      <= vsync_in;
      r_vsync_prev <= vsync_in;
    end
  end
endmodule

// File: tb/tb_starfield_fade_stage.sv
// tb_starfield_fade_stage: directed checks of fade pacing, dither pattern, sync alignment and reset
module tb_starfield_fade_stage;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       hsync_in = 1'b0, vsync_in = 1'b0, display_on = 1'b0;
  logic [9:0] hpos = '0, vpos = '0;
  logic [2:0] rgb_in = '0;
  logic       fade_in_req = 1'b0, fade_out_req = 1'b0;
  logic       hsync, vsync, busy;
  logic [2:0] rgb;
  logic [4:0] level;
  logic [15:0] m;
  int n_tests = 0, n_fail = 0;
  starfield_fade_stage dut (
    .clk(clk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .display_on(display_on), .hpos(hpos), .vpos(vpos), .rgb_in(rgb_in),
    .fade_in_req(fade_in_req), .fade_out_req(fade_out_req),
    .hsync(hsync), .vsync(vsync), .rgb(rgb), .level(level), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic tick();
    vsync_in = 1'b1;
    cyc();
    vsync_in = 1'b0;
    cyc();
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic pulse(input logic fin, input logic fout);
    fade_in_req  = fin;
    fade_out_req = fout;
    cyc();
    fade_in_req  = 1'b0;
    fade_out_req = 1'b0;
    cyc();
  endtask
  // Lit mask over one 4x4 tile, bit index v*4+h, with full-white input
  task automatic tile_mask(output logic [15:0] mask);
    display_on = 1'b1;
    rgb_in = 3'd7;
    mask = '0;
    for (int v = 0; v < 4; v++)
      for (int h = 0; h < 4; h++) begin
        hpos = 10'(64 + h);
        vpos = 10'(128 + v);
        cyc();
        mask[v*4+h] = (rgb == 3'd7);
      end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [7:0] ph = 8'b1011_0010, pv = 8'b0110_1100;
    rgb_in = 3'd7;
    display_on = 1'b1;
    hsync_in = 1'b1;
    repeat (3) cyc();
    chk("rst_rgb", 16'(rgb), 16'd0);
    chk("rst_level", 16'(level), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_hsync", 16'(hsync), 16'd0);
    chk("rst_vsync", 16'(vsync), 16'd0);
    reset = 1'b1;
    cyc();
    ticks(3);
    tile_mask(m);
    chk("dark_mask", m, 16'h0000);
    pulse(1'b1, 1'b0);
    chk("pend_busy", 16'(busy), 16'd0);
    tick();
    chk("acc_busy", 16'(busy), 16'd1);
    chk("acc_level", 16'(level), 16'd0);
    ticks(2);
    chk("lvl1", 16'(level), 16'd1);
    tile_mask(m);
    chk("mask_l1", m, 16'h0001);
    ticks(14);
    chk("lvl8", 16'(level), 16'd8);
    tile_mask(m);
    chk("mask_l8", m, 16'hA5A5);
    ticks(15);
    chk("lvl15", 16'(level), 16'd15);
    chk("busy15", 16'(busy), 16'd1);
    tick();
    chk("lvl16", 16'(level), 16'd16);
    chk("lit_busy", 16'(busy), 16'd0);
    tile_mask(m);
    chk("mask_l16", m, 16'hFFFF);
    rgb_in = 3'd7;
    cyc();
    for (int i = 0; i < 8; i++) begin
      rgb_in = 3'(i);
      chk("rgb_hold", 16'(rgb), i == 0 ? 16'd7 : 16'(i - 1));
      cyc();
      chk("rgb_dly", 16'(rgb), 16'(i));
    end
    pulse(1'b0, 1'b1);
    tick();
    chk("out_busy", 16'(busy), 16'd1);
    chk("out_lvl", 16'(level), 16'd16);
    ticks(12);
    chk("out_lvl10", 16'(level), 16'd10);
    tile_mask(m);
    chk("mask_l10", m, 16'hADA7);
    pulse(1'b1, 1'b0);
    tick();
    chk("rev_lvl", 16'(level), 16'd10);
    chk("rev_busy", 16'(busy), 16'd1);
    ticks(2);
    chk("rev_up", 16'(level), 16'd11);
    ticks(10);
    chk("rev_top", 16'(level), 16'd16);
    chk("rev_lit", 16'(busy), 16'd0);
    pulse(1'b0, 1'b1);
    ticks(33);
    chk("dark_lvl", 16'(level), 16'd0);
    chk("dark_busy", 16'(busy), 16'd0);
    pulse(1'b1, 1'b1);
    tick();
    chk("both_lvl", 16'(level), 16'd0);
    chk("both_busy", 16'(busy), 16'd0);
    tick();
    chk("both_clr", 16'(busy), 16'd0);
    pulse(1'b1, 1'b0);
    ticks(33);
    chk("relit", 16'(level), 16'd16);
    display_on = 1'b0;
    rgb_in = 3'd7;
    hsync_in = 1'b0;
    cyc();
    for (int i = 0; i < 8; i++) begin
      hsync_in = ph[i];
      vsync_in = pv[i];
      chk("hs_hold", 16'(hsync), i == 0 ? 16'd0 : 16'(ph[i-1]));
      cyc();
      chk("hs_dly", 16'(hsync), 16'(ph[i]));
      chk("vs_dly", 16'(vsync), 16'(pv[i]));
      chk("blank_rgb", 16'(rgb), 16'd0);
    end
    vsync_in = 1'b0;
    cyc();
    chk("sync_lit", 16'(level), 16'd16);
    pulse(1'b0, 1'b1);
    tick();
    ticks(14);
    chk("mid_lvl9", 16'(level), 16'd9);
    chk("mid_busy", 16'(busy), 16'd1);
    display_on = 1'b1;
    rgb_in = 3'd7;
    hpos = '0;
    vpos = '0;
    hsync_in = 1'b1;
    cyc();
    chk("mid_rgb", 16'(rgb), 16'd7);
    reset = 1'b0;
    #1;
    chk("arst_rgb", 16'(rgb), 16'd0);
    chk("arst_lvl", 16'(level), 16'd0);
    chk("arst_busy", 16'(busy), 16'd0);
    chk("arst_hs", 16'(hsync), 16'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/starfield_fade_stage.md
Name: starfield_fade_stage

Overview:
- Downstream stage of the starfield generator. Takes its 3-bit RGB, the raster position and the sync signals, and applies a frame-paced fade-in/fade-out.
- Fading uses 4x4 ordered dithering, because each colour channel is only 1 bit.
- Sits between the pattern generator and the VGA pins. Registers rgb, hsync and vsync together so all three stay aligned.

Parameters:
- FRAMES_PER_STEP, 2: frames per brightness step; legal range 1..255.
- SYNC_ACTIVE_HIGH, 1: polarity of vsync_in/hsync_in. The same polarity is used for the hsync/vsync outputs.

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-low reset
- hsync_in  in  1  horizontal sync from the timing generator
- vsync_in  in  1  vertical sync from the timing generator
- display_on  in  1  visible-area flag
- hpos  in  10  pixel column
- vpos  in  10  pixel row
- rgb_in  in  3  pixel colour from the starfield generator
- fade_in_req  in  1  one-cycle request pulse
- fade_out_req  in  1  one-cycle request pulse
- hsync  out  1  registered hsync_in
- vsync  out  1  registered vsync_in
- rgb  out  3  faded, registered pixel
- level  out  5  current brightness, 0..16
- busy  out  1  high while in FADE_IN or FADE_OUT

Behaviour:
- Reset (reset low, asynchronous):
  - state = DARK, level = 0, frame_cnt = 0, both pending flags = 0.
  - rgb = 0, busy = 0.
  - hsync and vsync = inactive level (!SYNC_ACTIVE_HIGH).
  - vsync_prev = inactive level, so no false frame tick occurs after reset.
- Latency: exactly 1 cycle for rgb, hsync and vsync.
  - hsync <= hsync_in; vsync <= vsync_in.
  - rgb <= (display_on && dith_on) ? rgb_in : 0.
- Dither threshold b = M[vpos[1:0]][hpos[1:0]], with M rows:
  - row 0: 0 8 2 10
  - row 1: 12 4 14 6
  - row 2: 3 11 1 9
  - row 3: 15 7 13 5
  - dith_on = (b < level), compared as 5-bit unsigned. Level 0 is fully black; level 16 is fully on.
- Frame tick: one-cycle pulse on the active edge of vsync_in (inactive->active transition), detected against the registered vsync_prev.
- Requests:
  - A pulse on either request sets its pending flag on any cycle.
  - Pending flags are consumed only on a frame tick.
  - If both flags are pending at a tick, both clear and state is unchanged.
  - A request arriving in the same cycle as a tick is counted as pending for that tick.
- State transitions, evaluated on a frame tick:
  - DARK:
    - in_pend -> FADE_IN, frame_cnt = 0.
    - out_pend -> clear it, stay in DARK.
  - FADE_IN:
    - out_pend -> FADE_OUT, level kept, frame_cnt = 0.
    - Otherwise frame_cnt++. When frame_cnt == FRAMES_PER_STEP-1: frame_cnt = 0 and level++.
    - If level reaches 16 -> LIT.
    - in_pend -> cleared, no effect.
  - LIT (level 16):
    - out_pend -> FADE_OUT, frame_cnt = 0.
    - in_pend -> cleared.
  - FADE_OUT: mirror of FADE_IN.
    - level-- per step; reaching 0 -> DARK.
    - in_pend reverses to FADE_IN.
- Level never wraps: saturates at 0 and 16.
- Fade timing: a full fade takes 16*FRAMES_PER_STEP frame ticks after the accepting tick.
- Reset mid-fade: returns immediately to DARK, level 0, outputs black.

Test Plan:
- Reset low for 3 cycles while rgb_in = 7, display_on = 1 -> rgb = 0, level = 0, busy = 0, hsync/vsync inactive. Release reset, no requests, 3 frames -> rgb stays 0.
- Pulse fade_in_req mid-frame, FRAMES_PER_STEP = 2:
  - At the next tick, busy = 1 and level = 0.
  - After 2 more ticks, level = 1.
  - After 32 ticks total from acceptance, level = 16, state LIT, busy = 0.
  - rgb == rgb_in delayed 1 cycle for every visible pixel.
- Level held at 1 (via fade-in, after 2 ticks), rgb_in = 7, display_on = 1 -> only pixels with hpos[1:0] = 0 and vpos[1:0] = 0 output 7.
- Level 8 -> exactly 8 of 16 pixels per 4x4 tile are lit.
- From LIT, pulse fade_out_req; at level 10 pulse fade_in_req -> at the next tick state FADE_IN, level still 10; it then rises to 16.
- Pulse both requests in the same frame while DARK -> at the tick both pending flags clear; level stays 0 and busy stays 0.
- Sync alignment, with display_on = 0 and level 16:
  - rgb is always 0.
  - hsync/vsync equal the inputs delayed exactly 1 cycle.
- Assert reset mid-fade at level 9 -> outputs go black asynchronously, with no clock edge needed.
